// File: rtl/hd_leakage_monitor.sv
// hd_leakage_monitor: per-simulation Hamming distance/weight/toggle recorder feeding a FWFT record FIFO.
// Optional macro TOGGLE_ACC_EN: enables POST-phase toggle accumulation; otherwise rec_toggles is tied 0.
module hd_leakage_monitor #(
    parameter int OUT_SIZE   = 8,
    parameter int CYCLES     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int HDW        = $clog2(OUT_SIZE + 1),
    parameter int TW         = $clog2(OUT_SIZE * CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                start,
    input  logic [OUT_SIZE-1:0] state_in,
    output logic                busy,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [15:0]         rec_sim_id,
    output logic [HDW-1:0]      rec_hd,
    output logic [HDW-1:0]      rec_hw,
    output logic [TW-1:0]       rec_toggles,
    output logic                overflow,
    output logic                start_err
);
    localparam int CW  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int AW1 = AW + 1;
    localparam int RW  = 16 + 2 * HDW + TW;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRE, POST, COMMIT} state_t;

    function automatic logic [HDW-1:0] popcount(input logic [OUT_SIZE-1:0] v);
        logic [HDW-1:0] n;
        n = '0;
        for (int i = 0; i < OUT_SIZE; i++) n = n + HDW'(v[i]);
        return n;
    endfunction

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [15:0]         sim_cnt_q, sim_cnt_d, sim_id_q, sim_id_d;
    logic [OUT_SIZE-1:0] pre_q, pre_d, post_q, post_d;
    logic                overflow_q, overflow_d, start_err_q, start_err_d;
    logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
    logic [RW-1:0]       mem_q [FIFO_DEPTH];
    logic [RW-1:0]       mem_d [FIFO_DEPTH];
    logic [TW-1:0]       toggles;
    logic [RW-1:0]       rec;
    logic                push_req, full, pop, push, drop;

    assign busy = state_q != IDLE;

    // Window sequencing: PRE and POST each last CYCLES clocks, then one COMMIT clock.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sim_cnt_d = clear ? '0 : sim_cnt_q;
        sim_id_d  = sim_id_q;
        pre_d     = pre_q;
        post_d    = post_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = PRE;
                cnt_d     = '0;
                sim_id_d  = sim_cnt_d;
                sim_cnt_d = sim_cnt_d + 16'd1;
            end
            PRE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    pre_d   = state_in;
                    cnt_d   = '0;
                    state_d = POST;
                end
            end
            POST: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    post_d  = state_in;
                    state_d = COMMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef TOGGLE_ACC_EN
    localparam int TW1 = TW + 1;
    logic [OUT_SIZE-1:0] prev_q, prev_d;
    logic [TW-1:0]       tog_q, tog_d;
    logic [TW:0]         tog_sum;

    // Accumulate per-cycle bit flips during POST, saturating at the field maximum.
    always_comb begin
        prev_d  = prev_q;
        tog_d   = tog_q;
        tog_sum = {1'b0, tog_q} + TW1'(popcount(state_in ^ prev_q));
        if (state_q == IDLE && start) tog_d = '0;
        if (state_q == PRE && cnt_q == LAST) prev_d = state_in;
        if (state_q == POST) begin
            tog_d  = tog_sum[TW] ? '1 : tog_sum[TW-1:0];
            prev_d = state_in;
        end
    end

    // Toggle accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            tog_q  <= '0;
        end else begin
            prev_q <= prev_d;
            tog_q  <= tog_d;
        end
    end

    assign toggles = tog_q;
`else
    assign toggles = '0;
`endif

    assign rec_valid = wr_q != rd_q;
    assign full      = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign pop       = rec_valid & rec_ready;
    assign push_req  = state_q == COMMIT;
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;
    assign rec       = {sim_id_q, popcount(pre_q ^ post_q), popcount(post_q), toggles};

    assign {rec_sim_id, rec_hd, rec_hw, rec_toggles} = rec_valid ? mem_q[rd_q[AW-1:0]] : '0;
    assign overflow  = overflow_q;
    assign start_err = start_err_q;

    // Record FIFO update and sticky flags; clear wins over a same-cycle set.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q[AW-1:0]] = rec;
        wr_d        = wr_q + AW1'(push);
        rd_d        = rd_q + AW1'(pop);
        overflow_d  = ~clear & (overflow_q | drop);
        start_err_d = ~clear & (start_err_q | (start & busy));
    end

    // State registers; reset discards any in-flight window and empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sim_cnt_q   <= '0;
            sim_id_q    <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            overflow_q  <= 1'b0;
            start_err_q <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sim_cnt_q   <= sim_cnt_d;
            sim_id_q    <= sim_id_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            overflow_q  <= overflow_d;
            start_err_q <= start_err_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            mem_q       <= mem_d;
        end
    end
endmodule
